insn_buffer: RTL

INSN_BUFFER -- requirements
Module: insn_buffer

---
 rtl/insn_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/insn_buffer.sv
// 8-entry circular instruction buffer between fetch (2-wide) and decode (2-wide).
// Latency: a written entry is visible one cycle later. Outputs come straight from the head entry.
// Backpressure: ib_allin = (registered count <= 6). Decode holds the offered bundle by dropping id_allin.
module insn_buffer (
  input  logic        clk,
  input  logic        rst_,
  input  logic        flush,
  input  logic [31:0] if_ib_pc_0,
  input  logic [31:0] if_ib_pc_1,
  input  logic [31:0] if_ib_insn_0,
  input  logic [31:0] if_ib_insn_1,
  input  logic [4:0]  if_ib_ptab_addr_0,
  input  logic [4:0]  if_ib_ptab_addr_1,
  input  logic        if_ib_valid_0,
  input  logic        if_ib_valid_1,
  input  logic [1:0]  if_ib_delot_flag,
  input  logic        if_valid_ns,
  output logic        ib_allin,
  output logic [31:0] ib_id_pc_0,
  output logic [31:0] ib_id_pc_1,
  output logic [31:0] ib_id_insn_0,
  output logic [31:0] ib_id_insn_1,
  output logic [4:0]  ib_id_ptab_addr_0,
  output logic [4:0]  ib_id_ptab_addr_1,
  output logic        ib_id_valid_0,
  output logic        ib_id_valid_1,
  output logic [1:0]  ib_id_delot_flag,
  output logic        ib_valid_ns,
  input  logic        id_allin
);

  localparam int DEPTH = 8;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] insn_mem  [DEPTH];
  logic [4:0]  ptab_mem  [DEPTH];
  logic        delot_mem [DEPTH];

  logic [2:0] head;
  logic [2:0] tail;
  logic [3:0] count;

  logic       push;
  logic       pop;
  logic [1:0] wr_num;
  logic [1:0] pop_num;
  logic [2:0] wr_idx1;
  logic [2:0] head_p1;
  logic       wr_en0;
  logic       wr_en1;

  // Room for a full 2-slot bundle is judged on the registered count only,
  // so a push can never land on an entry that is leaving in the same cycle.
  assign ib_allin      = (count <= 4'd6);
  assign push          = if_valid_ns && ib_allin && !flush;
  assign ib_id_valid_0 = (count >= 4'd1);
  assign ib_id_valid_1 = (count >= 4'd2);
  assign ib_valid_ns   = ib_id_valid_0;
  assign pop           = ib_valid_ns && id_allin && !flush;

  assign wr_num  = {1'b0, if_ib_valid_0} + {1'b0, if_ib_valid_1};
  assign pop_num = !pop ? 2'd0 : (ib_id_valid_1 ? 2'd2 : 2'd1);

  // Slot 1 packs directly behind slot 0 when slot 0 is written, else takes tail itself.
  assign wr_idx1 = tail + {2'b00, if_ib_valid_0};
  assign head_p1 = head + 3'd1;
  assign wr_en0  = rst_ && push && if_ib_valid_0;
  assign wr_en1  = rst_ && push && if_ib_valid_1;

  // Entry storage: up to two in-order writes per cycle; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en0) begin
      pc_mem[tail]    <= if_ib_pc_0;
      insn_mem[tail]  <= if_ib_insn_0;
      ptab_mem[tail]  <= if_ib_ptab_addr_0;
      delot_mem[tail] <= if_ib_delot_flag[0];
    end
    if (wr_en1) begin
      pc_mem[wr_idx1]    <= if_ib_pc_1;
      insn_mem[wr_idx1]  <= if_ib_insn_1;
      ptab_mem[wr_idx1]  <= if_ib_ptab_addr_1;
      delot_mem[wr_idx1] <= if_ib_delot_flag[1];
    end
  end

  // Pointer/occupancy update; reset beats flush, flush discards that cycle's push and pop.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      head  <= 3'd0;
      tail  <= 3'd0;
      count <= 4'd0;
    end else if (flush) begin
      head  <= 3'd0;
      tail  <= 3'd0;
      count <= 4'd0;
    end else begin
      head  <= head + {1'b0, pop_num};
      if (push) begin
        tail <= tail + {1'b0, wr_num};
      end
      count <= count + (push ? {2'b00, wr_num} : 4'd0) - {2'b00, pop_num};
    end
  end

  // Show-ahead output of the two oldest entries; an invalid slot reads as all zero.
  always_comb begin
    ib_id_pc_0        = 32'd0;
    ib_id_insn_0      = 32'd0;
    ib_id_ptab_addr_0 = 5'd0;
    ib_id_pc_1        = 32'd0;
    ib_id_insn_1      = 32'd0;
    ib_id_ptab_addr_1 = 5'd0;
    ib_id_delot_flag  = 2'b00;
    if (ib_id_valid_0) begin
      ib_id_pc_0          = pc_mem[head];
      ib_id_insn_0        = insn_mem[head];
      ib_id_ptab_addr_0   = ptab_mem[head];
      ib_id_delot_flag[0] = delot_mem[head];
    end
    if (ib_id_valid_1) begin
      ib_id_pc_1          = pc_mem[head_p1];
      ib_id_insn_1        = insn_mem[head_p1];
      ib_id_ptab_addr_1   = ptab_mem[head_p1];
      ib_id_delot_flag[1] = delot_mem[head_p1];
    end
  end

endmodule
